// File: rtl/read_stage_rr_scheduler.sv
// Round-robin scheduler sharing one VRF read-stage request slot among NREQ requesters.
// Latency: 1 cycle from acceptance to out_valid_o; one-entry registered output slot.
// Backpressure: in_ready_o is all-zero while the slot is full and out_ready_i is low, or during flush.
module read_stage_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic                clock_i,
    input  logic                reset_ni,
    input  logic [NREQ-1:0]     in_valid_i,
    output logic [NREQ-1:0]     in_ready_o,
    input  logic [NREQ*5-1:0]   in_vs_i,
    input  logic [NREQ*7-1:0]   in_offset_i,
    input  logic [NREQ*4-1:0]   in_groupIndex_i,
    input  logic [NREQ*4-1:0]   in_readSource_i,
    input  logic [NREQ*3-1:0]   in_instructionIndex_i,
    input  logic                flush_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [4:0]          out_vs_o,
    output logic [6:0]          out_offset_o,
    output logic [3:0]          out_groupIndex_o,
    output logic [3:0]          out_readSource_o,
    output logic [2:0]          out_instructionIndex_o,
    output logic [IDXW-1:0]     out_grantIndex_o
);

    localparam logic [IDXW:0]   NREQ_W    = (IDXW+1)'(NREQ);
    localparam logic [IDXW-1:0] LAST_INIT = IDXW'(NREQ - 1);

    logic            run_q;
    logic            out_valid_q, out_valid_d;
    logic [4:0]      vs_q, vs_d;
    logic [6:0]      offset_q, offset_d;
    logic [3:0]      group_q, group_d;
    logic [3:0]      source_q, source_d;
    logic [2:0]      instr_q, instr_d;
    logic [IDXW-1:0] grant_q, grant_d;
    logic [IDXW-1:0] last_grant_q, last_grant_d;

    logic            win_vld;
    logic [IDXW-1:0] win_idx;
    logic [IDXW:0]   scan;
    logic            can_accept;
    logic            accept;

    // Scan starts one past the last grant and wraps modulo NREQ.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        scan    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan = {1'b0, last_grant_q} + (IDXW+1)'(k);
            if (scan >= NREQ_W) begin
                scan = scan - NREQ_W;
            end
            if (!win_vld && in_valid_i[scan[IDXW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = scan[IDXW-1:0];
            end
        end
    end

    // run_q keeps in_ready_o low until the first edge after reset release.
    assign can_accept = run_q && !flush_i && (!out_valid_q || out_ready_i);
    assign accept     = win_vld && can_accept;
    assign in_ready_o = accept ? (NREQ'(1) << win_idx) : '0;

    always_comb begin
        out_valid_d  = out_valid_q;
        vs_d         = vs_q;
        offset_d     = offset_q;
        group_d      = group_q;
        source_d     = source_q;
        instr_d      = instr_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d  = 1'b1;
            vs_d         = in_vs_i[int'(win_idx)*5 +: 5];
            offset_d     = in_offset_i[int'(win_idx)*7 +: 7];
            group_d      = in_groupIndex_i[int'(win_idx)*4 +: 4];
            source_d     = in_readSource_i[int'(win_idx)*4 +: 4];
            instr_d      = in_instructionIndex_i[int'(win_idx)*3 +: 3];
            grant_d      = win_idx;
            last_grant_d = win_idx;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            run_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            vs_q         <= '0;
            offset_q     <= '0;
            group_q      <= '0;
            source_q     <= '0;
            instr_q      <= '0;
            grant_q      <= '0;
            last_grant_q <= LAST_INIT;
        end else begin
            run_q        <= 1'b1;
            out_valid_q  <= out_valid_d;
            vs_q         <= vs_d;
            offset_q     <= offset_d;
            group_q      <= group_d;
            source_q     <= source_d;
            instr_q      <= instr_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid_o            = out_valid_q;
    assign out_vs_o               = vs_q;
    assign out_offset_o           = offset_q;
    assign out_groupIndex_o       = group_q;
    assign out_readSource_o       = source_q;
    assign out_instructionIndex_o = instr_q;
    assign out_grantIndex_o       = grant_q;

endmodule

// File: tb/tb_read_stage_rr_scheduler.sv
// Bench for read_stage_rr_scheduler: cycle table with expected in_ready/out_valid/grant plus
// a scoreboard of accepted requests compared on each downstream handshake.
module tb_read_stage_rr_scheduler;

    localparam int NREQ = 4;
    localparam int IDXW = 2;

    logic                clock;
    logic                reset_n;
    logic [NREQ-1:0]     in_valid;
    logic [NREQ-1:0]     in_ready;
    logic [NREQ*5-1:0]   in_vs;
    logic [NREQ*7-1:0]   in_offset;
    logic [NREQ*4-1:0]   in_group;
    logic [NREQ*4-1:0]   in_source;
    logic [NREQ*3-1:0]   in_instr;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [4:0]          out_vs;
    logic [6:0]          out_offset;
    logic [3:0]          out_group;
    logic [3:0]          out_source;
    logic [2:0]          out_instr;
    logic [IDXW-1:0]     out_grant;

    read_stage_rr_scheduler #(.NREQ(NREQ), .IDXW(IDXW)) dut (
        .clock_i                (clock),
        .reset_ni               (reset_n),
        .in_valid_i             (in_valid),
        .in_ready_o             (in_ready),
        .in_vs_i                (in_vs),
        .in_offset_i            (in_offset),
        .in_groupIndex_i        (in_group),
        .in_readSource_i        (in_source),
        .in_instructionIndex_i  (in_instr),
        .flush_i                (flush),
        .out_valid_o            (out_valid),
        .out_ready_i            (out_ready),
        .out_vs_o               (out_vs),
        .out_offset_o           (out_offset),
        .out_groupIndex_o       (out_group),
        .out_readSource_o       (out_source),
        .out_instructionIndex_o (out_instr),
        .out_grantIndex_o       (out_grant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] gnt;
        logic [4:0] vs;
        logic [6:0] off;
        logic [3:0] grp;
        logic [3:0] src;
        logic [2:0] ins;
    } entry_t;

    typedef struct {
        logic [3:0] v;
        logic       r;
        logic       f;
        logic [3:0] rdy;
        logic       ovld;
        logic [1:0] gnt;
    } vec_t;

    vec_t   vecs[$];
    entry_t sb[$];
    int     total = 0;
    int     bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic entry_t observed();
        entry_t e;
        e.gnt = out_grant;
        e.vs  = out_vs;
        e.off = out_offset;
        e.grp = out_group;
        e.src = out_source;
        e.ins = out_instr;
        return e;
    endfunction

    function automatic entry_t expected_of(input int idx);
        entry_t e;
        e.gnt = 2'(idx);
        e.vs  = in_vs[idx*5 +: 5];
        e.off = in_offset[idx*7 +: 7];
        e.grp = in_group[idx*4 +: 4];
        e.src = in_source[idx*4 +: 4];
        e.ins = in_instr[idx*3 +: 3];
        return e;
    endfunction

    task automatic add(input logic [3:0] v, input logic r, input logic f,
                       input logic [3:0] rdy, input logic ovld, input logic [1:0] gnt);
        vec_t t;
        t.v = v; t.r = r; t.f = f; t.rdy = rdy; t.ovld = ovld; t.gnt = gnt;
        vecs.push_back(t);
    endtask

    task automatic randomize_fields();
        in_vs     = (NREQ*5)'($urandom);
        in_offset = (NREQ*7)'($urandom);
        in_group  = (NREQ*4)'($urandom);
        in_source = (NREQ*4)'($urandom);
        in_instr  = (NREQ*3)'($urandom);
    endtask

    initial begin
        entry_t e_exp;
        int     idx;

        //   valid    rdy  flush  exp_ready ovld gnt
        add(4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 2'd0);
        add(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2);
        add(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
        add(4'b1111, 1'b1, 1'b0, 4'b1000, 1'b0, 2'd0);
        add(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd3);
        add(4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0);
        add(4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1);
        add(4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd2);
        add(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd3);
        add(4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0);
        add(4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1);
        add(4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd2);
        add(4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd3);
        add(4'b1001, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1);
        add(4'b1001, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1);
        add(4'b1001, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1);
        add(4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd1);
        add(4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd3);
        add(4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd1);
        add(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3);
        add(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
        add(4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0);
        add(4'b0001, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0);
        add(4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0);
        add(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0);
        add(4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 2'd0);
        add(4'b0001, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd2);
        add(4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0);
        add(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0);
        add(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);

        reset_n   = 1'b0;
        in_valid  = 4'b1111;
        flush     = 1'b0;
        out_ready = 1'b1;
        randomize_fields();
        #3;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(observed()), 32'd0);
        #20 reset_n = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid  = vecs[i].v;
            out_ready = vecs[i].r;
            flush     = vecs[i].f;
            randomize_fields();
            if (i == 0) begin
                in_vs[2*5 +: 5]     = 5'd9;
                in_offset[2*7 +: 7] = 7'd33;
                in_group[2*4 +: 4]  = 4'd3;
                in_source[2*4 +: 4] = 4'd1;
                in_instr[2*3 +: 3]  = 3'd4;
            end
            @(negedge clock);
            check($sformatf("in_ready[%0d]", i), 32'(in_ready), 32'(vecs[i].rdy));
            check($sformatf("out_valid[%0d]", i), 32'(out_valid), 32'(vecs[i].ovld));
            if (vecs[i].ovld)
                check($sformatf("grant[%0d]", i), 32'(out_grant), 32'(vecs[i].gnt));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check($sformatf("sb_underflow[%0d]", i), 32'd1, 32'd0);
                end else begin
                    e_exp = sb.pop_front();
                    check($sformatf("sb_entry[%0d]", i), 32'(observed()), 32'(e_exp));
                end
            end else if (out_valid && flush) begin
                if (sb.size() != 0) void'(sb.pop_front());
            end
            if (vecs[i].rdy != 4'b0000) begin
                idx = 0;
                for (int k = 0; k < NREQ; k++)
                    if (vecs[i].rdy[k]) idx = k;
                sb.push_back(expected_of(idx));
            end
            @(posedge clock);
            #1;
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        // Fill the slot, then hit it with an asynchronous reset mid-cycle.
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_vs[2*5 +: 5] = 5'd17;
        @(posedge clock);
        #1;
        check("pre_reset_full", 32'(out_valid), 32'd1);
        check("pre_reset_vs", 32'(out_vs), 32'd17);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(out_valid), 32'd0);
        check("async_reset_data", 32'(observed()), 32'd0);
        check("async_reset_ready", 32'(in_ready), 32'd0);
        sb.delete();
        #1 reset_n = 1'b1;
        in_valid  = 4'b0011;
        out_ready = 1'b1;
        #1;
        check("post_release_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;
        check("post_reset_first_grant", 32'(in_ready), 32'b0001);
        check("post_reset_empty", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;
        check("post_reset_valid", 32'(out_valid), 32'd1);
        check("post_reset_grant", 32'(out_grant), 32'd0);
        check("post_reset_next", 32'(in_ready), 32'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
